// File: rtl/seg_scan_pkg.sv
// Shared types and counter-width helpers for the 7-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Width of a modulo-n counter; a modulus of 1 still needs one bit of storage.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned presc_w(input int unsigned scan_div);
    return cnt_w(scan_div);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_digits);
    return cnt_w(num_digits);
  endfunction

  function automatic int unsigned blink_w(input int unsigned blink_div);
    return cnt_w(blink_div);
  endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Generic modulo-N counter with count enable and a same-cycle wrap pulse.
module seg_tick_div
  import seg_scan_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap_c
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;
  logic         at_last;

  always_comb begin
    at_last = (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (en) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign wrap_c = en & at_last;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner with guard interval, blank/blink masks and
// frame-aligned double-buffered digit updates.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned GUARD      = 2,
  parameter int unsigned BLINK_DIV  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic                          load_ack,
  output logic                          frame_start,
  output logic [DIGIT_W-1:0]            dig_bin,
  output logic                          dig_en,
  output logic [NUM_DIGITS-1:0]         dig_sel
);

  localparam int unsigned PW = presc_w(SCAN_DIV);
  localparam int unsigned IW = idx_w(NUM_DIGITS);
  localparam int unsigned BW = blink_w(BLINK_DIV);

  localparam logic [PW-1:0] GUARD_C = PW'(GUARD);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [BW-1:0] unused_blink_cnt;
  logic          tick_c;
  logic          frame_wrap_c;
  logic          blink_wrap_c;

  seg_tick_div #(.N(SCAN_DIV), .W(PW)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .cnt    (presc),
    .wrap_c (tick_c)
  );

  seg_tick_div #(.N(NUM_DIGITS), .W(IW)) u_idx (
    .clk    (clk),
    .rst    (rst),
    .en     (tick_c),
    .cnt    (idx),
    .wrap_c (frame_wrap_c)
  );

  seg_tick_div #(.N(BLINK_DIV), .W(BW)) u_blink (
    .clk    (clk),
    .rst    (rst),
    .en     (frame_wrap_c),
    .cnt    (unused_blink_cnt),
    .wrap_c (blink_wrap_c)
  );

  digit_t [NUM_DIGITS-1:0] shadow_d, shadow_q;
  digit_t [NUM_DIGITS-1:0] active_d, active_q;
  logic                    pending_d, pending_q;
  logic                    blink_phase_d, blink_phase_q;
  logic                    wrap_seen_d, wrap_seen_q;
  logic                    commit_seen_d, commit_seen_q;
  logic                    commit_c;

  logic [NUM_DIGITS-1:0]   dig_sel_d, dig_sel_q;
  digit_t                  dig_bin_d, dig_bin_q;
  logic                    dig_en_d, dig_en_q;
  logic                    frame_start_d, frame_start_q;
  logic                    load_ack_d, load_ack_q;
  logic                    dark_c;
  logic                    lit_c;

  // Shadow/active buffering: a commit takes the shadow as it was before this edge.
  always_comb begin
    commit_c      = frame_wrap_c & pending_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    if (load) begin
      shadow_d = digits_in;
    end
    if (commit_c) begin
      active_d = shadow_q;
    end
    pending_d     = load | (pending_q & ~commit_c);
    blink_phase_d = blink_phase_q ^ blink_wrap_c;
    wrap_seen_d   = frame_wrap_c;
    commit_seen_d = commit_c;
  end

  // Display outputs derived from the current scan position, one cycle behind it.
  always_comb begin
    dark_c        = blank_mask[idx] | (blink_mask[idx] & blink_phase_q);
    lit_c         = (presc >= GUARD_C) & ~dark_c;
    dig_sel_d     = '1;
    dig_en_d      = lit_c;
    dig_bin_d     = active_q[idx];
    frame_start_d = wrap_seen_q;
    load_ack_d    = commit_seen_q;
    if (lit_c) begin
      dig_sel_d = ~(NUM_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      blink_phase_q <= 1'b0;
      wrap_seen_q   <= 1'b0;
      commit_seen_q <= 1'b0;
      dig_sel_q     <= '1;
      dig_bin_q     <= '0;
      dig_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      blink_phase_q <= blink_phase_d;
      wrap_seen_q   <= wrap_seen_d;
      commit_seen_q <= commit_seen_d;
      dig_sel_q     <= dig_sel_d;
      dig_bin_q     <= dig_bin_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign dig_sel     = dig_sel_q;
  assign dig_bin     = dig_bin_q;
  assign dig_en      = dig_en_q;
  assign frame_start = frame_start_q;
  assign load_ack    = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4-cycle slots, 1 guard cycle.
module tb_seg_scan_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned G  = 1;
  localparam int unsigned BD = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [15:0]  digits_in;
  logic [3:0]   blink_mask;
  logic [3:0]   blank_mask;
  logic         load_ack;
  logic         frame_start;
  logic [3:0]   dig_bin;
  logic         dig_en;
  logic [3:0]   dig_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .GUARD      (G),
    .BLINK_DIV  (BD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digits_in   (digits_in),
    .blink_mask  (blink_mask),
    .blank_mask  (blank_mask),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .dig_bin     (dig_bin),
    .dig_en      (dig_en),
    .dig_sel     (dig_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " sel"}, 32'(dig_sel), 32'hF);
    chk({tag, " en"},  32'(dig_en), 32'h0);
    chk({tag, " bin"}, 32'(dig_bin), 32'h0);
    chk({tag, " fs"},  32'(frame_start), 32'h0);
    chk({tag, " ack"}, 32'(load_ack), 32'h0);
  endtask

  // Expected output for output cycle j of a 16-cycle frame.
  task automatic chk_cycle(input int f, input int j, input logic [15:0] digs,
                           input logic [3:0] dark, input logic fs_first,
                           input logic ack_first);
    int         slot;
    int         pos;
    logic       lit;
    logic [3:0] sel;
    logic [15:0] dv;
    logic [3:0] bin;
    slot = j / 4;
    pos  = j % 4;
    lit  = (pos != 0) && !dark[slot];
    sel  = lit ? ~(4'b0001 << slot) : 4'b1111;
    dv   = digs;
    bin  = dv[slot*4 +: 4];
    chk($sformatf("f%0d.%0d sel", f, j), 32'(dig_sel), 32'(sel));
    chk($sformatf("f%0d.%0d en", f, j), 32'(dig_en), 32'(lit));
    if (!dark[slot]) begin
      chk($sformatf("f%0d.%0d bin", f, j), 32'(dig_bin), 32'(bin));
    end
    chk($sformatf("f%0d.%0d fs", f, j), 32'(frame_start), 32'((j == 0) ? fs_first : 1'b0));
    chk($sformatf("f%0d.%0d ack", f, j), 32'(load_ack), 32'((j == 0) ? ack_first : 1'b0));
  endtask

  // One full frame; k1/k2 are internal cycles of this frame in which load is high.
  task automatic run_frame(input int f, input logic [15:0] digs, input logic [3:0] dark,
                           input logic fs_first, input logic ack_first,
                           input int k1, input logic [15:0] v1,
                           input int k2, input logic [15:0] v2);
    for (int j = 0; j < 16; j++) begin
      step();
      chk_cycle(f, j, digs, dark, fs_first, ack_first);
      load = 1'b0;
      if (j + 1 == k1) begin
        load      = 1'b1;
        digits_in = v1;
      end
      if (j + 1 == k2) begin
        load      = 1'b1;
        digits_in = v2;
      end
    end
    load = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    digits_in  = 16'h0;
    blink_mask = 4'h0;
    blank_mask = 4'h0;
    repeat (3) step();
    chk_reset("por");
    rst = 1'b0;

    run_frame(0, 16'h0000, 4'h0, 1'b0, 1'b0, 5, 16'h4321, -1, 16'h0);
    run_frame(1, 16'h4321, 4'h0, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame(2, 16'h4321, 4'h0, 1'b1, 1'b0, 9, 16'h9999, -1, 16'h0);
    run_frame(3, 16'h9999, 4'h0, 1'b1, 1'b1, 3, 16'h1111, 10, 16'h2222);
    run_frame(4, 16'h2222, 4'h0, 1'b1, 1'b1, 7, 16'h5555, 15, 16'h3333);
    run_frame(5, 16'h5555, 4'h0, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame(6, 16'h3333, 4'h0, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame(7, 16'h3333, 4'h0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    blink_mask = 4'b0010;
    blank_mask = 4'b1000;
    for (int f = 8; f < 14; f++) begin
      run_frame(f, 16'h3333, (((f / 2) % 2) != 0) ? 4'b1010 : 4'b1000,
                1'b1, 1'b0, -1, 16'h0, -1, 16'h0);
    end
    blink_mask = 4'h0;
    blank_mask = 4'h0;

    for (int j = 0; j < 9; j++) begin
      step();
      chk_cycle(14, j, 16'h3333, 4'h0, 1'b1, 1'b0);
      load = 1'b0;
      if (j + 1 == 3) begin
        load      = 1'b1;
        digits_in = 16'h7777;
      end
    end
    rst = 1'b1;
    step();
    chk_reset("mid");
    rst = 1'b0;

    run_frame(15, 16'h0000, 4'h0, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(16, 16'h0000, 4'h0, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
